// File: rtl/ssd_pkg.sv
// Shared constants for the score seven-segment driver: digit geometry and
// active-low segment patterns ordered {a,b,c,d,e,f,g}.
package ssd_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BCD_W      = 4;
   localparam int unsigned SCORE_W    = NUM_DIGITS * BCD_W;
   localparam int unsigned SEG_W      = 8;

   localparam logic [SEG_W-1:0] SSD_BLANK = 8'hFF;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;

   // Non-decimal nibbles come back all-off.
   function automatic logic [6:0] seg_pattern(input logic [BCD_W-1:0] d);
      logic [6:0] p;
      p = 7'h7F;
      case (d)
         4'd0: p = SEG_0;
         4'd1: p = SEG_1;
         4'd2: p = SEG_2;
         4'd3: p = SEG_3;
         4'd4: p = SEG_4;
         4'd5: p = SEG_5;
         4'd6: p = SEG_6;
         4'd7: p = SEG_7;
         4'd8: p = SEG_8;
         4'd9: p = SEG_9;
         default: p = 7'h7F;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit saturating BCD incrementer with synchronous clear and a sticky
// overflow flag raised by an increment attempted at 9999.
module bcd_counter4
   import ssd_pkg::*;
(
   input  logic               board_clk,
   input  logic               Reset,
   input  logic               i_inc,
   input  logic               i_clr,
   output logic [SCORE_W-1:0] o_count,
   output logic               o_overflow
);

   localparam logic [SCORE_W-1:0] ALL_NINES = 16'h9999;

   logic [SCORE_W-1:0] r_count;
   logic               r_overflow;
   logic [SCORE_W-1:0] w_next;

   // Ripple carry digit by digit, ones first.
   always_comb begin : p_next
      logic w_carry;
      w_next  = r_count;
      w_carry = 1'b1;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         if (w_carry) begin
            if (r_count[d*BCD_W +: BCD_W] == 4'd9) begin
               w_next[d*BCD_W +: BCD_W] = 4'd0;
            end else begin
               w_next[d*BCD_W +: BCD_W] = r_count[d*BCD_W +: BCD_W] + 4'd1;
               w_carry = 1'b0;
            end
         end
      end
   end

   // Clear dominates a coincident increment.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_clr) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_inc) begin
         if (r_count == ALL_NINES) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= w_next;
         end
      end
   end

   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/score_ssd_driver.sv
// Score/high-score keeper that scans the selected value onto a four-anode
// seven-segment display with active-low anodes and segments.
module score_ssd_driver
   import ssd_pkg::*;
#(
   parameter int unsigned SCAN_DIV_BITS = 18,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic                  board_clk,
   input  logic                  Reset,
   input  logic                  score_pulse,
   input  logic                  game_reset,
   input  logic                  show_high,
   output logic [SCORE_W-1:0]    score_bcd,
   output logic [SCORE_W-1:0]    high_bcd,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] an,
   output logic [SEG_W-1:0]      seg
);

   localparam int unsigned SCAN_W = SCAN_DIV_BITS + 2;

   logic                  r_sp_s1, r_sp_s2, r_sp_s3;
   logic                  r_gr_s1, r_gr_s2;
   logic                  r_inc;
   logic                  w_edge;
   logic [SCORE_W-1:0]    w_score;
   logic                  w_overflow;
   logic [SCORE_W-1:0]    r_high;
   logic [SCAN_W-1:0]     r_scan;
   logic [1:0]            w_digit;
   logic [SCORE_W-1:0]    w_disp;
   logic [BCD_W-1:0]      w_nib;
   logic                  w_blank;
   logic                  w_dp;
   logic [NUM_DIGITS-1:0] w_an;
   logic [SEG_W-1:0]      w_seg;
   logic [NUM_DIGITS-1:0] r_an;
   logic [SEG_W-1:0]      r_seg;

   // Synchronisers; the rising-edge strobe is registered once more before use.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_sp_s1 <= 1'b0;
         r_sp_s2 <= 1'b0;
         r_sp_s3 <= 1'b0;
         r_gr_s1 <= 1'b0;
         r_gr_s2 <= 1'b0;
         r_inc   <= 1'b0;
      end else begin
         r_sp_s1 <= score_pulse;
         r_sp_s2 <= r_sp_s1;
         r_sp_s3 <= r_sp_s2;
         r_gr_s1 <= game_reset;
         r_gr_s2 <= r_gr_s1;
         r_inc   <= w_edge;
      end
   end

   assign w_edge = r_sp_s2 & ~r_sp_s3;

   bcd_counter4 u_counter (
      .board_clk  (board_clk),
      .Reset      (Reset),
      .i_inc      (r_inc),
      .i_clr      (r_gr_s2),
      .o_count    (w_score),
      .o_overflow (w_overflow)
   );

   // Valid BCD orders the same as plain binary, so a direct compare is MSD-first.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_high <= '0;
      end else if (w_score > r_high) begin
         r_high <= w_score;
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_scan <= '0;
      end else begin
         r_scan <= r_scan + SCAN_W'(1);
      end
   end

   assign w_digit = r_scan[SCAN_W-1 -: 2];

   // Digit select, leading-zero blanking and segment decode for the active slot.
   always_comb begin
      w_disp  = show_high ? r_high : w_score;
      w_nib   = w_disp[32'(w_digit)*BCD_W +: BCD_W];
      w_blank = (BLANK_LEADING != 0) && (w_digit != 2'd0) &&
                ((w_disp >> (32'(w_digit)*BCD_W)) == '0);
      w_dp    = ~(show_high && (w_digit == 2'd0));
      w_an    = w_blank ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << w_digit);
      w_seg   = SSD_BLANK;
      if (!w_blank && (w_nib <= 4'd9)) begin
         w_seg = {seg_pattern(w_nib), w_dp};
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_an  <= {NUM_DIGITS{1'b1}};
         r_seg <= SSD_BLANK;
      end else begin
         r_an  <= w_an;
         r_seg <= w_seg;
      end
   end

   assign score_bcd = w_score;
   assign high_bcd  = r_high;
   assign overflow  = w_overflow;
   assign an        = r_an;
   assign seg       = r_seg;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Scoreboard bench for score_ssd_driver: stimulus queues expected score, high
// score and display frames; monitors pop and compare as the DUT changes.
module tb_score_ssd_driver;

   localparam int unsigned TB_SCAN = 2;

   logic        board_clk = 1'b0;
   logic        Reset;
   logic        score_pulse;
   logic        game_reset;
   logic        show_high;
   logic [15:0] score_bcd;
   logic [15:0] high_bcd;
   logic        overflow;
   logic [3:0]  an;
   logic [7:0]  seg;

   score_ssd_driver #(.SCAN_DIV_BITS(TB_SCAN), .BLANK_LEADING(1)) dut (
      .board_clk   (board_clk),
      .Reset       (Reset),
      .score_pulse (score_pulse),
      .game_reset  (game_reset),
      .show_high   (show_high),
      .score_bcd   (score_bcd),
      .high_bcd    (high_bcd),
      .overflow    (overflow),
      .an          (an),
      .seg         (seg)
   );

   always #5 board_clk = ~board_clk;

   logic [6:0] pat [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int sc_cyc   = 0;

   logic [15:0] sc_q [$];
   logic [15:0] hi_q [$];
   logic [47:0] disp_q [$];
   logic        disp_busy = 1'b0;

   logic [15:0] exp_score = '0;
   logic [15:0] exp_high  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   // Expected {an,seg} for each of the four slots, slot k at bits [12k +: 12].
   function automatic logic [47:0] exp_disp(input logic [15:0] v, input logic hi);
      logic [47:0] r;
      logic [3:0]  nib;
      logic [3:0]  a;
      logic [7:0]  s;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         nib = v[k*4 +: 4];
         if (k > 0 && (v >> (4 * k)) == 16'h0) begin
            a = 4'hF;
            s = 8'hFF;
         end else begin
            a = ~(4'b0001 << k);
            s = {pat[nib], (k == 0 && hi) ? 1'b0 : 1'b1};
         end
         r[k*12 +: 12] = {a, s};
      end
      return r;
   endfunction

   always @(posedge board_clk or posedge Reset) begin
      if (Reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Score / high-score monitor.
   initial begin
      logic [15:0] prev_sc, prev_hi;
      prev_sc = '0;
      prev_hi = '0;
      forever begin
         @(negedge board_clk);
         if (Reset) begin
            prev_sc = score_bcd;
            prev_hi = high_bcd;
         end else begin
            if (score_bcd !== prev_sc) begin
               if (sc_q.size() == 0) check("score_unexpected", 32'(score_bcd), 32'(prev_sc));
               else                  check("score", 32'(score_bcd), 32'(sc_q.pop_front()));
               sc_cyc  = cyc;
               prev_sc = score_bcd;
            end
            if (high_bcd !== prev_hi) begin
               if (hi_q.size() == 0) check("high_unexpected", 32'(high_bcd), 32'(prev_hi));
               else                  check("high", 32'(high_bcd), 32'(hi_q.pop_front()));
               check("high_lag", 32'(cyc - sc_cyc), 32'd1);
               prev_hi = high_bcd;
            end
         end
      end
   end

   // Display monitor: one queued frame is checked over a full 16-cycle scan.
   initial begin
      logic [47:0] fr;
      int          k;
      forever begin
         @(negedge board_clk);
         if (disp_q.size() > 0) begin
            fr        = disp_q.pop_front();
            disp_busy = 1'b1;
            for (int i = 0; i < 16; i++) begin
               if (i > 0) @(negedge board_clk);
               k = ((cyc - 1) >> TB_SCAN) & 3;
               check($sformatf("disp_slot%0d", k), 32'({an, seg}), 32'(fr[k*12 +: 12]));
            end
            disp_busy = 1'b0;
         end
      end
   end

   task automatic pulse(input int hi, input int lo);
      score_pulse = 1'b1;
      if (exp_score != 16'h9999) begin
         exp_score = int2bcd(bcd2int(exp_score) + 1);
         sc_q.push_back(exp_score);
         if (bcd2int(exp_score) > bcd2int(exp_high)) begin
            exp_high = exp_score;
            hi_q.push_back(exp_high);
         end
      end
      repeat (hi) @(negedge board_clk);
      score_pulse = 1'b0;
      repeat (lo) @(negedge board_clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && (sc_q.size() != 0 || hi_q.size() != 0); i++)
         @(negedge board_clk);
      check("drain_pending", 32'(sc_q.size() + hi_q.size()), 32'd0);
   endtask

   task automatic disp_req(input logic [47:0] fr);
      bit done;
      done = 1'b0;
      disp_q.push_back(fr);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge board_clk);
         if (disp_q.size() == 0 && !disp_busy) done = 1'b1;
      end
      check("disp_done", 32'(done), 32'd1);
   endtask

   initial begin
      int  c;
      bit  found;
      Reset       = 1'b1;
      score_pulse = 1'b0;
      game_reset  = 1'b0;
      show_high   = 1'b0;
      repeat (3) @(negedge board_clk);
      check("rst_score", 32'(score_bcd), 32'h0);
      check("rst_high",  32'(high_bcd),  32'h0);
      check("rst_ovf",   32'(overflow),  32'h0);
      check("rst_an",    32'(an),        32'hF);
      check("rst_seg",   32'(seg),       32'hFF);
      Reset = 1'b0;
      repeat (2) @(negedge board_clk);
      disp_req(exp_disp(16'h0000, 1'b0));

      // First pulse also measures the input-to-score latency.
      c = cyc;
      pulse(4, 4);
      check("latency", 32'(sc_cyc - c), 32'd4);
      repeat (11) pulse(4, 4);
      drain();
      check("score_12", 32'(score_bcd), 32'h0012);
      disp_req(exp_disp(16'h0012, 1'b0));

      while (exp_score != 16'h0999) pulse(1, 1);
      drain();
      pulse(1, 1);
      drain();
      check("score_1000", 32'(score_bcd), 32'h1000);
      disp_req(exp_disp(16'h1000, 1'b0));

      while (exp_score != 16'h9999) pulse(1, 1);
      drain();
      pulse(1, 1);
      repeat (6) @(negedge board_clk);
      check("sat_score", 32'(score_bcd), 32'h9999);
      check("sat_ovf",   32'(overflow),  32'h1);

      // Asynchronous reset while digit 2 is lit.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge board_clk);
         if (an == 4'b1011) found = 1'b1;
      end
      check("digit2_seen", 32'(found), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("arst_an",    32'(an),        32'hF);
      check("arst_seg",   32'(seg),       32'hFF);
      check("arst_score", 32'(score_bcd), 32'h0);
      check("arst_high",  32'(high_bcd),  32'h0);
      check("arst_ovf",   32'(overflow),  32'h0);
      exp_score = '0;
      exp_high  = '0;
      sc_q.delete();
      hi_q.delete();
      repeat (2) @(negedge board_clk);
      Reset = 1'b0;
      @(negedge board_clk);
      check("restart_an", 32'(an), 32'hE);

      repeat (25) pulse(1, 1);
      drain();
      // game_reset and a score edge arrive together; the clear wins.
      score_pulse = 1'b1;
      game_reset  = 1'b1;
      exp_score   = '0;
      sc_q.push_back(exp_score);
      repeat (4) @(negedge board_clk);
      score_pulse = 1'b0;
      repeat (4) @(negedge board_clk);
      game_reset = 1'b0;
      repeat (4) @(negedge board_clk);
      drain();
      check("gr_score", 32'(score_bcd), 32'h0);
      check("gr_ovf",   32'(overflow),  32'h0);
      check("gr_high",  32'(high_bcd),  32'h0025);
      show_high = 1'b1;
      repeat (2) @(negedge board_clk);
      disp_req(exp_disp(16'h0025, 1'b1));
      show_high = 1'b0;
      repeat (2) @(negedge board_clk);

      repeat (7) pulse(1, 1);
      drain();
      check("high_hold", 32'(high_bcd), 32'h0025);
      repeat (19) pulse(1, 1);
      drain();
      check("score_26", 32'(score_bcd), 32'h0026);
      check("high_26",  32'(high_bcd),  32'h0026);

      repeat (4) @(negedge board_clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
